// File: rtl/store_rmw_sequencer_if.sv
// Memory-side bus of the store read-modify-write sequencer.
// The sequencer drives it through the master modport; the memory answers through the slave modport.
interface store_rmw_sequencer_if;
  logic [31:0] mem_addr;
  logic        mem_rd;
  logic        mem_wr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  modport master (output mem_addr, output mem_rd, output mem_wr, output mem_wdata,
                  input  mem_rdata);
  modport slave  (input  mem_addr, input  mem_rd, input  mem_wr, input  mem_wdata,
                  output mem_rdata);
endinterface

// File: rtl/store_rmw_sequencer.sv
// Multicycle read-modify-write sequencer for SW/SH/SB; sub-word stores merge into the read word.
// Optional misalignment abort is enabled by defining STORE_ALIGN_CHECK_EN.
module store_rmw_sequencer #(
  parameter int MEM_LAT = 1,
  parameter int CNT_W   = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic [1:0]                    store_size,
  input  logic [31:0]                   addr,
  input  logic [31:0]                   b_in,
  output logic                          busy,
  output logic                          done,
  output logic                          err,
  store_rmw_sequencer_if.master         mem
);

`ifdef STORE_ALIGN_CHECK_EN
  typedef enum logic [2:0] {S_IDLE, S_READ, S_CAPTURE, S_WRITE, S_DONE, S_ERR} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_READ, S_CAPTURE, S_WRITE, S_DONE} state_t;
`endif

  state_t             state, state_nx;
  logic [CNT_W-1:0]   cnt;
  logic [31:0]        addr_q;
  logic [15:0]        b_q;
  logic [1:0]         size_q;
  logic [31:0]        wdata_q;

  function automatic logic is_word(input logic [1:0] sz);
    return (sz == 2'b00) || (sz == 2'b11);
  endfunction

  function automatic logic [31:0] merge_sub(input logic [31:0] rd, input logic [15:0] b,
                                            input logic [1:0] sz);
    if (sz == 2'b01) return {rd[31:8], b[7:0]};
    return {rd[31:16], b};
  endfunction

`ifdef STORE_ALIGN_CHECK_EN
  function automatic logic misaligned(input logic [1:0] sz, input logic [1:0] a);
    return ((sz == 2'b10) && a[0]) || (is_word(sz) && (a != 2'b00));
  endfunction
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx     = state;
    busy         = 1'b1;
    done         = 1'b0;
    err          = 1'b0;
    mem.mem_rd   = 1'b0;
    mem.mem_wr   = 1'b0;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) begin
          state_nx = is_word(store_size) ? S_WRITE : S_READ;
`ifdef STORE_ALIGN_CHECK_EN
          if (misaligned(store_size, addr[1:0])) state_nx = S_ERR;
`endif
        end
      end
      S_READ: begin
        mem.mem_rd = 1'b1;
        if (cnt == CNT_W'(MEM_LAT - 1)) state_nx = S_CAPTURE;
      end
      S_CAPTURE: state_nx = S_WRITE;
      S_WRITE: begin
        mem.mem_wr = 1'b1;
        state_nx   = S_DONE;
      end
      S_DONE: begin
        done     = 1'b1;
        state_nx = S_IDLE;
      end
`ifdef STORE_ALIGN_CHECK_EN
      S_ERR: begin
        err      = 1'b1;
        state_nx = S_IDLE;
      end
`endif
      default: state_nx = S_IDLE;
    endcase
  end

  // The write-data register doubles as the MDR: the read word is merged as it is captured.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_q  <= '0;
      b_q     <= '0;
      size_q  <= '0;
      wdata_q <= '0;
      cnt     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            addr_q <= addr;
            b_q    <= b_in[15:0];
            size_q <= store_size;
            cnt    <= '0;
            if (is_word(store_size)) wdata_q <= b_in;
          end
        end
        S_READ:    cnt     <= cnt + CNT_W'(1);
        S_CAPTURE: wdata_q <= merge_sub(mem.mem_rdata, b_q, size_q);
        default: ;
      endcase
    end
  end

  assign mem.mem_addr  = addr_q;
  assign mem.mem_wdata = wdata_q;

  // The latency counter must never wrap while reads are outstanding.
  cnt_no_wrap_a: assert property (@(posedge clk) disable iff (!reset)
    (state == S_READ) |-> (int'(cnt) < MEM_LAT));

endmodule

// File: tb/tb_store_rmw_sequencer.sv
// Scoreboard bench for store_rmw_sequencer: random and directed SW/SH/SB stores against a memory model.
// Builds with or without STORE_ALIGN_CHECK_EN.
module tb_store_rmw_sequencer;
  localparam int MEM_LAT = 2;
  localparam int CNT_W   = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  store_size = 2'b00;
  logic [31:0] addr = '0;
  logic [31:0] b_in = '0;
  logic        busy, done, err;

  store_rmw_sequencer_if mif();

  store_rmw_sequencer #(.MEM_LAT(MEM_LAT), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .start(start), .store_size(store_size), .addr(addr),
    .b_in(b_in), .busy(busy), .done(done), .err(err), .mem(mif.master));

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    bit          is_err;
    int          start_cyc;
    int          wr_lat;
    int          rd_exp;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] mem_arr [16];
  logic [31:0] ref_mem [16];
  int          cyc = 0;
  int          n_chk = 0;
  int          n_pass = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
  endtask

  // Memory model: read data is only meaningful after mem_rd was held exactly MEM_LAT cycles.
  int run = 0;
  always @(negedge clk) begin
    if (mif.mem_rd) begin
      run = run + 1;
      mif.mem_rdata = $urandom;
    end else begin
      mif.mem_rdata = (run == MEM_LAT) ? mem_arr[mif.mem_addr[5:2]] : $urandom;
      run = 0;
    end
    if (mif.mem_wr) mem_arr[mif.mem_addr[5:2]] = mif.mem_wdata;
  end

  // Monitor: pops the scoreboard whenever the DUT presents a write, done or err.
  int rd_cnt  = 0;
  bit wr_seen = 0;
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      rd_cnt  = 0;
      wr_seen = 0;
    end else begin
      if (mif.mem_rd || mif.mem_wr) chk("rd_wr_exclusive", 32'(mif.mem_rd & mif.mem_wr), 0);
      if (mif.mem_rd) rd_cnt++;
      if (mif.mem_wr) begin
        chk("wr_expected", 32'(sb.size() != 0), 1);
        if (sb.size() != 0) begin
          e = sb[0];
          chk("wr_not_err",  32'(e.is_err), 0);
          chk("mem_addr",    mif.mem_addr, e.addr);
          chk("mem_wdata",   mif.mem_wdata, e.wdata);
          chk("wr_latency",  cyc - e.start_cyc, e.wr_lat);
          chk("rd_cycles",   rd_cnt, e.rd_exp);
          chk("single_wr",   32'(wr_seen), 0);
          wr_seen = 1;
        end
      end
      if (done) begin
        chk("done_expected", 32'(sb.size() != 0), 1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("done_latency", cyc - e.start_cyc, e.wr_lat + 1);
          chk("done_after_wr", 32'(wr_seen), 1);
          chk("busy_in_done", 32'(busy), 1);
        end
        wr_seen = 0;
        rd_cnt  = 0;
      end
      if (err) begin
        chk("err_expected", 32'(sb.size() != 0), 1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("err_is_err",  32'(e.is_err), 1);
          chk("err_latency", cyc - e.start_cyc, 1);
          chk("err_no_rd",   rd_cnt, 0);
          chk("err_no_wr",   32'(wr_seen), 0);
        end
        rd_cnt = 0;
      end
    end
  end

  task automatic push_expected(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] b);
    exp_t        e;
    int          idx;
    bit          word;
    logic [31:0] w;
    idx  = int'(a[5:2]);
    word = (sz == 2'b00) || (sz == 2'b11);
    e.addr      = a;
    e.start_cyc = cyc;
    e.is_err    = 0;
`ifdef STORE_ALIGN_CHECK_EN
    if ((sz == 2'b10 && a[0]) || (word && a[1:0] != 2'b00)) e.is_err = 1;
`endif
    e.wr_lat = word ? 1 : MEM_LAT + 2;
    e.rd_exp = word ? 0 : MEM_LAT;
    w = ref_mem[idx];
    if (word)              w = b;
    else if (sz == 2'b01)  w[7:0]  = b[7:0];
    else                   w[15:0] = b[15:0];
    e.wdata = w;
    if (!e.is_err) ref_mem[idx] = w;
    sb.push_back(e);
  endtask

  task automatic issue(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start = 1'b1; store_size = sz; addr = a; b_in = b;
    push_expected(sz, a, b);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    while (sb.size() != 0 && n < 60) begin
      @(negedge clk); #1;
      n++;
    end
    chk({nm, "_complete"}, sb.size(), 0);
    sb.delete();
    @(negedge clk); #1;
    chk({nm, "_busy_idle"}, 32'(busy), 0);
  endtask

  task automatic preload(input int idx, input logic [31:0] v);
    mem_arr[idx] = v;
    ref_mem[idx] = v;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 16; i++) preload(i, $urandom);

    repeat (2) @(negedge clk);
    chk("rst_mem_rd",    32'(mif.mem_rd), 0);
    chk("rst_mem_wr",    32'(mif.mem_wr), 0);
    chk("rst_busy",      32'(busy), 0);
    chk("rst_done",      32'(done), 0);
    chk("rst_err",       32'(err), 0);
    chk("rst_mem_addr",  mif.mem_addr, 0);
    chk("rst_mem_wdata", mif.mem_wdata, 0);
    reset = 1'b1;

    // Directed: SW, SB and SH against a known word.
    issue(2'b00, 32'h10, 32'hDEADBEEF);
    wait_idle("sw");
    preload(5, 32'h11223344);
    issue(2'b01, 32'h14, 32'hAABBCCDD);
    wait_idle("sb");
    chk("sb_mem_word", mem_arr[5], 32'h112233DD);
    preload(6, 32'h11223344);
    issue(2'b10, 32'h18, 32'h0000BEEF);
    wait_idle("sh");
    chk("sh_mem_word", mem_arr[6], 32'h1122BEEF);

    // start held high with junk inputs throughout an SB: only the first request counts.
    preload(7, 32'h55667788);
    @(negedge clk);
    start = 1'b1; store_size = 2'b01; addr = 32'h1C; b_in = 32'h000000A5;
    push_expected(2'b01, 32'h1C, 32'h000000A5);
    for (int i = 0; i < 30; i++) begin
      @(negedge clk); #1;
      if (sb.size() == 0) break;
      store_size = 2'($urandom); addr = $urandom; b_in = $urandom;
    end
    start = 1'b0;
    wait_idle("spam");
    chk("spam_mem_word", mem_arr[7], 32'h556677A5);

    // Reset during CAPTURE: outputs drop immediately and the write never happens.
    preload(8, 32'hCAFEF00D);
    issue(2'b01, 32'h20, 32'h00000011);
    @(negedge clk); @(negedge clk);
    chk("pre_rst_capture_rd", 32'(mif.mem_rd), 0);
    chk("pre_rst_capture_busy", 32'(busy), 1);
    #2 reset = 1'b0;
    sb.delete();
    ref_mem[8] = 32'hCAFEF00D;
    #1;
    chk("midrst_mem_rd",    32'(mif.mem_rd), 0);
    chk("midrst_mem_wr",    32'(mif.mem_wr), 0);
    chk("midrst_busy",      32'(busy), 0);
    chk("midrst_done",      32'(done), 0);
    chk("midrst_mem_addr",  mif.mem_addr, 0);
    chk("midrst_mem_wdata", mif.mem_wdata, 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (6) @(negedge clk);
    chk("midrst_mem_untouched", mem_arr[8], 32'hCAFEF00D);
    issue(2'b00, 32'h24, 32'h01234567);
    wait_idle("post_rst_sw");

`ifdef STORE_ALIGN_CHECK_EN
    issue(2'b10, 32'h11, 32'h0000BEEF);
    wait_idle("misaligned_sh");
`endif

    // Random stores over all sizes and address low bits.
    for (int i = 0; i < 40; i++) begin
      logic [31:0] a;
      a = {26'($urandom), 6'($urandom)};
      issue(2'($urandom), a, $urandom);
      wait_idle("rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
